ft_lockstep_checker: RTL and testbench
======================================

# ft_lockstep_checker

Dual-core lockstep checker placed directly downstream of the two zeroriscy cores in the multi-core SoC. It consumes each core's granted instruction-fetch addresses and buffers them in per-core FIFOs to absorb bounded skew. It compares the streams in order and, on divergence, overflow or excessive skew, halts both cores by gating their fetch enables. It also latches a diagnostic error code and the offending address until software or the testbench clears it.

## Interface
- ADDR_W, 32, fetch address width
- DEPTH, 4, entries per per-core FIFO (power of two, ≥2)
- TIMEOUT, 16, max consecutive cycles one FIFO may be non-empty while the other is empty
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- enable_i  in  1  checker active; low = bypass, no pushes, no errors raised
- fetch_enable_i  in  1  upstream fetch enable for both cores
- c1_valid_i  in  1  core 1 fetch granted this cycle
- c1_addr_i  in  ADDR_W  core 1 granted fetch address
- c2_valid_i  in  1  core 2 fetch granted this cycle
- c2_addr_i  in  ADDR_W  core 2 granted fetch address
- clear_i  in  1  leave HALT: flush FIFOs, clear error state
- fetch_enable_1_o  out  1  gated fetch enable, core 1
- fetch_enable_2_o  out  1  gated fetch enable, core 2
- error_o  out  1  sticky error flag
- err_code_o  out  2  00 none, 01 mismatch, 10 overflow, 11 skew timeout
- mismatch_addr_o  out  ADDR_W  core 1 head address at the time of the error (0 for overflow/timeout)
- match_count_o  out  16  compared-equal pairs since reset/clear, saturating at 0xFFFF

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- RUN with enable_i=1:
  - c1_valid_i pushes c1_addr_i into FIFO1, and c2_valid_i pushes into FIFO2, at the same edge.
  - When both FIFOs are non-empty, the heads are compared combinationally and both are popped at the next edge.
  - Equal heads: match_count_o increments, saturating.
- Error detection and priority:
  - Unequal heads → HALT, err_code 01, mismatch_addr_o ← FIFO1 head.
  - A push into a full FIFO with no pop that cycle → HALT, err_code 10. Push plus pop on a full FIFO is legal.
  - Skew counter: increments while exactly one FIFO is non-empty and resets otherwise. Reaching TIMEOUT → HALT, err_code 11.
  - Simultaneous error priority: mismatch > overflow > timeout.
- HALT:
  - error_o=1; both fetch enables driven 0.
  - Pushes ignored; all outputs hold.
  - clear_i: FIFOs flushed, skew counter and match_count cleared, error_o/err_code_o/mismatch_addr_o cleared, state → RUN.
- clear_i in RUN: flush and counter clear only.
- enable_i=0:
  - fetch_enable_*_o = fetch_enable_i.
  - No pushes or compares; the FIFOs and counters hold.
  - A pending HALT is not released by enable_i.

## Timing
- Reset values:
  - FSM = RUN; FIFOs empty.
  - error_o=0, err_code_o=00, mismatch_addr_o=0, match_count_o=0, skew counter=0.
  - fetch_enable_*_o follow fetch_enable_i combinationally (error_o=0).
- fetch_enable_*_o = fetch_enable_i & ~error_o (combinational).
- Mismatch latency:
  - Both valids at edge k into empty FIFOs → compare during cycle k+1.
  - error_o high after edge k+1; enables drop in that same cycle.
- Overflow: error_o rises after the offending edge.
- Timeout: error_o rises exactly TIMEOUT cycles after one-sided occupancy begins.
- Reset asserted mid-operation clears everything immediately, independent of the clock.

## Structure
- Package ft_checker_pkg holds:
  - the state_e enum {RUN, HALT};
  - the err_code_e enum {ERR_NONE, ERR_MISMATCH, ERR_OVERFLOW, ERR_TIMEOUT};
  - match-count width constant 16.
- Sub-module ft_addr_fifo:
  - synchronous FIFO, ADDR_W × DEPTH, with push/pop/flush, full/empty, head data;
  - instantiated twice.

## Test plan
- Lockstep match: both cores push 0x0, 0x4, 0x8 on the same cycles → match_count_o=3, error_o=0, enables follow fetch_enable_i.
- Skewed match: core 2 lags core 1 by 3 cycles on 0x80..0x8C (DEPTH=4) → no error, match_count_o=4.
- Mismatch: core 1 pushes 0x100, core 2 pushes 0x104 on the same edge → one cycle later error_o=1, err_code_o=01, mismatch_addr_o=0x100, both enables 0; clear_i → RUN, error_o=0.
- Overflow: core 1 pushes 5 addresses, core 2 silent (DEPTH=4) → err_code_o=10 after the 5th push edge.
- Timeout: core 1 pushes once, core 2 silent → err_code_o=11 exactly 16 cycles later; assert rst_ni low mid-HALT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/ft_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ft_checker_pkg
// Purpose  : Shared types and constants for the dual-core lockstep checker.
//            state_e    - checker FSM states (RUN, HALT)
//            err_code_e - diagnostic error code reported on err_code_o
//            MATCH_CNT_W- width of the saturating matched-pair counter
// Revision : 1.0 - initial release
// ============================================================================
package ft_checker_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISMATCH = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_e;

    localparam int MATCH_CNT_W = 16;

endpackage : ft_checker_pkg
`default_nettype wire

// File: rtl/ft_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ft_addr_fifo
// Purpose  : Small synchronous FIFO of fetch addresses, ADDR_W x DEPTH.
//            Head data is presented combinationally for comparison.
// Ports    : clk_i    - clock
//            rst_ni   - asynchronous active-low reset
//            push_i   - write data_i (ignored when full unless popping too)
//            pop_i    - discard head entry (ignored when empty)
//            flush_i  - empty the FIFO; takes priority over push/pop
//            data_i   - address to write
//            full_o   - FIFO holds DEPTH entries
//            empty_o  - FIFO holds no entries
//            head_o   - oldest entry (undefined content when empty)
// Revision : 1.0 - initial release
// ============================================================================
module ft_addr_fifo #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves at the
    // same edge; the write then lands in the slot being vacated.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : ft_addr_fifo
`default_nettype wire

// File: rtl/ft_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module   : ft_lockstep_checker
// Purpose  : Dual-core lockstep checker. Buffers each core's granted fetch
//            addresses, compares the two streams in order and halts both
//            cores (gates their fetch enables) on divergence, FIFO overflow
//            or excessive skew. A diagnostic code and offending address are
//            latched until clear_i.
// Ports    : clk_i, rst_ni          - clock, async active-low reset
//            enable_i               - checker active (low = bypass)
//            fetch_enable_i         - upstream fetch enable
//            c1_valid_i/c1_addr_i   - core 1 granted fetch
//            c2_valid_i/c2_addr_i   - core 2 granted fetch
//            clear_i                - flush, clear counters/errors, go RUN
//            fetch_enable_1_o/_2_o  - gated fetch enables
//            error_o                - sticky error flag
//            err_code_o             - 00 none/01 mismatch/10 overflow/11 skew
//            mismatch_addr_o        - core 1 head address at a mismatch
//            match_count_o          - saturating count of equal pairs
// Revision : 1.0 - initial release
// ============================================================================
module ft_lockstep_checker
    import ft_checker_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   fetch_enable_i,
    input  logic                   c1_valid_i,
    input  logic [ADDR_W-1:0]      c1_addr_i,
    input  logic                   c2_valid_i,
    input  logic [ADDR_W-1:0]      c2_addr_i,
    input  logic                   clear_i,
    output logic                   fetch_enable_1_o,
    output logic                   fetch_enable_2_o,
    output logic                   error_o,
    output logic [1:0]             err_code_o,
    output logic [ADDR_W-1:0]      mismatch_addr_o,
    output logic [MATCH_CNT_W-1:0] match_count_o
);

    localparam int SKEW_W = $clog2(TIMEOUT + 1);

    state_e                  state_q,         state_d;
    err_code_e               err_code_q,      err_code_d;
    logic [ADDR_W-1:0]       mismatch_addr_q, mismatch_addr_d;
    logic [MATCH_CNT_W-1:0]  match_count_q,   match_count_d;
    logic [SKEW_W-1:0]       skew_q,          skew_d;

    logic              push1, push2, pop, flush;
    logic              full1, full2, empty1, empty2;
    logic [ADDR_W-1:0] head1, head2;

    logic active;
    logic both_ne;
    logic one_sided;
    logic mismatch;
    logic overflow;
    logic timeout;

    ft_addr_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push1),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (c1_addr_i),
        .full_o  (full1),
        .empty_o (empty1),
        .head_o  (head1)
    );

    ft_addr_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push2),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (c2_addr_i),
        .full_o  (full2),
        .empty_o (empty2),
        .head_o  (head2)
    );

    assign active    = (state_q == RUN) && enable_i;
    assign both_ne   = !empty1 && !empty2;
    assign one_sided = empty1 ^ empty2;

    // Heads are popped whenever both are present, so an incoming push on a
    // full FIFO is only an overflow when no compare is happening this cycle.
    assign mismatch = active && both_ne && (head1 != head2);
    assign overflow = active && !both_ne &&
                      ((c1_valid_i && full1) || (c2_valid_i && full2));
    // skew_q counts completed one-sided cycles; the edge that would make it
    // reach TIMEOUT is the one that raises the error.
    assign timeout  = active && one_sided && (skew_q == SKEW_W'(TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        err_code_d      = err_code_q;
        mismatch_addr_d = mismatch_addr_q;
        match_count_d   = match_count_q;
        skew_d          = skew_q;
        push1           = 1'b0;
        push2           = 1'b0;
        pop             = 1'b0;
        flush           = 1'b0;

        if (clear_i) begin
            flush           = 1'b1;
            skew_d          = '0;
            match_count_d   = '0;
            err_code_d      = ERR_NONE;
            mismatch_addr_d = '0;
            state_d         = RUN;
        end else if (active) begin
            push1 = c1_valid_i;
            push2 = c2_valid_i;
            pop   = both_ne;

            if (both_ne && !mismatch && (match_count_q != '1)) begin
                match_count_d = match_count_q + 1'b1;
            end

            skew_d = one_sided ? (skew_q + 1'b1) : '0;

            if (mismatch) begin
                state_d         = HALT;
                err_code_d      = ERR_MISMATCH;
                mismatch_addr_d = head1;
            end else if (overflow) begin
                state_d         = HALT;
                err_code_d      = ERR_OVERFLOW;
                mismatch_addr_d = '0;
            end else if (timeout) begin
                state_d         = HALT;
                err_code_d      = ERR_TIMEOUT;
                mismatch_addr_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= RUN;
            err_code_q      <= ERR_NONE;
            mismatch_addr_q <= '0;
            match_count_q   <= '0;
            skew_q          <= '0;
        end else begin
            state_q         <= state_d;
            err_code_q      <= err_code_d;
            mismatch_addr_q <= mismatch_addr_d;
            match_count_q   <= match_count_d;
            skew_q          <= skew_d;
        end
    end

    assign error_o          = (state_q == HALT);
    assign err_code_o       = err_code_q;
    assign mismatch_addr_o  = mismatch_addr_q;
    assign match_count_o    = match_count_q;
    assign fetch_enable_1_o = fetch_enable_i & ~error_o;
    assign fetch_enable_2_o = fetch_enable_i & ~error_o;

endmodule : ft_lockstep_checker
`default_nettype wire

// File: tb/tb_ft_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft_lockstep_checker
// Purpose  : Directed self-checking bench for ft_lockstep_checker with
//            default parameters (ADDR_W=32, DEPTH=4, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft_lockstep_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fetch_en;
    logic        c1_valid;
    logic [31:0] c1_addr;
    logic        c2_valid;
    logic [31:0] c2_addr;
    logic        clear;
    logic        fe1;
    logic        fe2;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] mm_addr;
    logic [15:0] match_cnt;

    int tests  = 0;
    int failed = 0;

    ft_lockstep_checker #(
        .ADDR_W  (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .fetch_enable_i   (fetch_en),
        .c1_valid_i       (c1_valid),
        .c1_addr_i        (c1_addr),
        .c2_valid_i       (c2_valid),
        .c2_addr_i        (c2_addr),
        .clear_i          (clear),
        .fetch_enable_1_o (fe1),
        .fetch_enable_2_o (fe2),
        .error_o          (error),
        .err_code_o       (err_code),
        .mismatch_addr_o  (mm_addr),
        .match_count_o    (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        fetch_en = 1'b1;
        c1_valid = 1'b0;
        c1_addr  = '0;
        c2_valid = 1'b0;
        c2_addr  = '0;
        clear    = 1'b0;

        // Reset state
        #2;
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        check("rst_addr", mm_addr, 32'd0);
        check("rst_match", {16'b0, match_cnt}, 32'd0);
        check("rst_fe1", {31'b0, fe1}, 32'd1);
        check("rst_fe2", {31'b0, fe2}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Lockstep match: 0x0, 0x4, 0x8 on both cores
        c1_valid = 1'b1; c2_valid = 1'b1;
        c1_addr = 32'h0; c2_addr = 32'h0; tick();
        c1_addr = 32'h4; c2_addr = 32'h4; tick();
        c1_addr = 32'h8; c2_addr = 32'h8; tick();
        c1_valid = 1'b0; c2_valid = 1'b0;
        tick();
        check("lock_match", {16'b0, match_cnt}, 32'd3);
        check("lock_error", {31'b0, error}, 32'd0);
        check("lock_fe1", {31'b0, fe1}, 32'd1);
        fetch_en = 1'b0;
        #1;
        check("lock_fe1_follow", {31'b0, fe1}, 32'd0);
        check("lock_fe2_follow", {31'b0, fe2}, 32'd0);
        fetch_en = 1'b1;

        // Clear in RUN zeroes the counter
        do_clear();
        check("clr_run_match", {16'b0, match_cnt}, 32'd0);
        check("clr_run_error", {31'b0, error}, 32'd0);

        // Skewed match: core 2 lags by 3 cycles on 0x80..0x8C
        for (int t = 0; t < 7; t++) begin
            c1_valid = (t < 4);
            c1_addr  = 32'h80 + 32'(4 * t);
            c2_valid = (t >= 3);
            c2_addr  = 32'h80 + 32'(4 * (t - 3));
            tick();
        end
        c1_valid = 1'b0; c2_valid = 1'b0;
        tick();
        tick();
        check("skew_match", {16'b0, match_cnt}, 32'd4);
        check("skew_error", {31'b0, error}, 32'd0);

        // Mismatch: 0x100 vs 0x104
        c1_valid = 1'b1; c1_addr = 32'h100;
        c2_valid = 1'b1; c2_addr = 32'h104;
        tick();
        c1_valid = 1'b0; c2_valid = 1'b0;
        check("mm_not_yet", {31'b0, error}, 32'd0);
        tick();
        check("mm_error", {31'b0, error}, 32'd1);
        check("mm_code", {30'b0, err_code}, 32'd1);
        check("mm_addr", mm_addr, 32'h100);
        check("mm_fe1", {31'b0, fe1}, 32'd0);
        check("mm_fe2", {31'b0, fe2}, 32'd0);
        check("mm_match_hold", {16'b0, match_cnt}, 32'd4);
        // HALT ignores pushes and holds outputs
        c1_valid = 1'b1; c1_addr = 32'h200;
        tick(); tick();
        c1_valid = 1'b0;
        check("halt_code_hold", {30'b0, err_code}, 32'd1);
        check("halt_addr_hold", mm_addr, 32'h100);
        do_clear();
        check("mm_clr_error", {31'b0, error}, 32'd0);
        check("mm_clr_code", {30'b0, err_code}, 32'd0);
        check("mm_clr_addr", mm_addr, 32'd0);
        check("mm_clr_match", {16'b0, match_cnt}, 32'd0);
        check("mm_clr_fe1", {31'b0, fe1}, 32'd1);

        // Overflow: five pushes on core 1, core 2 silent
        c1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c1_addr = 32'h300 + 32'(4 * i);
            tick();
        end
        check("ovf_not_yet", {31'b0, error}, 32'd0);
        c1_addr = 32'h310;
        tick();
        c1_valid = 1'b0;
        check("ovf_error", {31'b0, error}, 32'd1);
        check("ovf_code", {30'b0, err_code}, 32'd2);
        check("ovf_addr", mm_addr, 32'd0);
        do_clear();
        check("ovf_clr_error", {31'b0, error}, 32'd0);

        // Timeout: single push on core 1, core 2 silent
        c1_valid = 1'b1; c1_addr = 32'h400;
        tick();
        c1_valid = 1'b0;
        repeat (15) tick();
        check("to_not_yet", {31'b0, error}, 32'd0);
        tick();
        check("to_error", {31'b0, error}, 32'd1);
        check("to_code", {30'b0, err_code}, 32'd3);
        check("to_addr", mm_addr, 32'd0);

        // Asynchronous reset mid-HALT, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_error", {31'b0, error}, 32'd0);
        check("arst_code", {30'b0, err_code}, 32'd0);
        check("arst_fe1", {31'b0, fe1}, 32'd1);
        check("arst_fe2", {31'b0, fe2}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Bypass: enable low pushes nothing, so no skew timeout
        enable   = 1'b0;
        c1_valid = 1'b1; c1_addr = 32'h500;
        repeat (20) tick();
        c1_valid = 1'b0;
        check("byp_error", {31'b0, error}, 32'd0);
        check("byp_fe1", {31'b0, fe1}, 32'd1);
        enable = 1'b1;

        // Checker resumes normally afterwards
        c1_valid = 1'b1; c1_addr = 32'h600;
        c2_valid = 1'b1; c2_addr = 32'h600;
        tick();
        c1_valid = 1'b0; c2_valid = 1'b0;
        tick();
        check("resume_match", {16'b0, match_cnt}, 32'd1);
        check("resume_error", {31'b0, error}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ft_lockstep_checker
`default_nettype wire
